// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT sample feeder path.
package fft_pkg;

  localparam int FFT_BIT_WIDTH  = 32;
  localparam int FFT_DECIMAL_PT = 16;
  localparam int FFT_N_SAMPLES  = 8;

  typedef logic [FFT_BIT_WIDTH-1:0] sample_t;
  typedef logic                     bank_sel_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return bank_sel_t'(~b);
  endfunction

endpackage

// File: rtl/fft_sample_deserializer_frame_bank.sv
// One frame of sample storage, written one sample at a time, read as a whole frame.
module frame_bank #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                we,
  input  logic [$clog2(N_SAMPLES)-1:0]        waddr,
  input  logic [BIT_WIDTH-1:0]                wdata,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] data
);

  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] mem_r;

  // Sample storage; cleared on reset so stale frames never reach the FFT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r <= '0;
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign data = mem_r;

endmodule

// File: rtl/fft_sample_deserializer.sv
// Serial-to-parallel frame assembler with ping-pong banks feeding the FFT recv port.
module fft_sample_deserializer
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = FFT_BIT_WIDTH,
  parameter int DECIMAL_PT = FFT_DECIMAL_PT,
  parameter int N_SAMPLES  = FFT_N_SAMPLES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BIT_WIDTH-1:0]                recv_msg,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg,
  output logic                                send_val,
  input  logic                                send_rdy
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  generate
    if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0) ||
        (DECIMAL_PT < 0) || (DECIMAL_PT > BIT_WIDTH)) begin : g_bad_params
      $error("fft_sample_deserializer: illegal parameter set");
    end
  endgenerate

  logic [1:0]        full_r;
  logic [1:0]        full_nxt_s;
  bank_sel_t         wr_bank_r;
  bank_sel_t         rd_bank_r;
  logic [IDX_W-1:0]  wr_idx_r;
  logic              live_r;
  logic              accept_s;
  logic              take_s;
  logic              last_s;
  logic [1:0]        bank_we_s;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] bank_data_s [2];

  assign recv_rdy = live_r & ~full_r[wr_bank_r];
  assign send_val = full_r[rd_bank_r];
  assign accept_s = recv_val & recv_rdy;
  assign take_s   = send_val & send_rdy;
  assign last_s   = (wr_idx_r == LAST_IDX);

  // Full-flag update; set and clear always address different banks
  always_comb begin
    full_nxt_s = full_r;
    if (take_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s = full_nxt_s;
    end
    if (accept_s && last_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s = full_nxt_s;
    end
  end

  // Pointer and flag registers; live_r keeps recv_rdy low until the first edge after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_idx_r  <= '0;
      live_r    <= 1'b0;
    end else begin
      live_r <= 1'b1;
      full_r <= full_nxt_s;
      if (accept_s) begin
        if (last_s) begin
          wr_idx_r  <= '0;
          wr_bank_r <= other_bank(wr_bank_r);
        end else begin
          wr_idx_r <= wr_idx_r + IDX_W'(1);
        end
      end
      if (take_s) begin
        rd_bank_r <= other_bank(rd_bank_r);
      end
    end
  end

  assign bank_we_s[0] = accept_s & (wr_bank_r == 1'b0);
  assign bank_we_s[1] = accept_s & (wr_bank_r == 1'b1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .BIT_WIDTH (BIT_WIDTH),
      .N_SAMPLES (N_SAMPLES)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (bank_we_s[b]),
      .waddr (wr_idx_r),
      .wdata (recv_msg),
      .data  (bank_data_s[b])
    );
  end

  assign send_msg = rd_bank_r ? bank_data_s[1] : bank_data_s[0];

endmodule

// File: tb/tb_fft_sample_deserializer.sv
// Directed self-checking bench for fft_sample_deserializer (N_SAMPLES=8, BIT_WIDTH=32).
module tb_fft_sample_deserializer;
  import fft_pkg::*;

  localparam int BW = 32;
  localparam int NS = 8;

  logic                         clk;
  logic                         reset;
  logic [BW-1:0]                recv_msg;
  logic                         recv_val;
  logic                         recv_rdy;
  logic [NS-1:0][BW-1:0]        send_msg;
  logic                         send_val;
  logic                         send_rdy;

  int n_cmp;
  int n_err;

  fft_sample_deserializer #(
    .BIT_WIDTH  (BW),
    .DECIMAL_PT (16),
    .N_SAMPLES  (NS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic test_reset();
    reset = 1'b0; recv_val = 1'b1; recv_msg = 32'hDEAD_BEEF; send_rdy = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (recv_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %0b want 0", recv_rdy); end
    n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL reset_val got %0b want 0", send_val); end
    reset = 1'b1;
    #1;
    n_cmp++; if (recv_rdy !== 1'b0) begin n_err++; $display("FAIL release_rdy_early got %0b want 0", recv_rdy); end
    @(negedge clk);
    n_cmp++; if (recv_rdy !== 1'b1) begin n_err++; $display("FAIL release_rdy got %0b want 1", recv_rdy); end
    n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL release_val got %0b want 0", send_val); end
    recv_val = 1'b0;
  endtask

  task automatic test_single_frame();
    send_rdy = 1'b1;
    for (int i = 1; i <= NS; i++) begin
      @(negedge clk);
      n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL single_early_val s%0d got %0b want 0", i, send_val); end
      n_cmp++; if (recv_rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy s%0d got %0b want 1", i, recv_rdy); end
      recv_msg = 32'(i); recv_val = 1'b1;
    end
    @(negedge clk);
    recv_val = 1'b0;
    n_cmp++; if (send_val !== 1'b1) begin n_err++; $display("FAIL single_val got %0b want 1", send_val); end
    for (int k = 0; k < NS; k++) begin
      n_cmp++; if (send_msg[k] !== 32'(k + 1)) begin n_err++; $display("FAIL single_msg[%0d] got %0d want %0d", k, send_msg[k], k + 1); end
    end
    @(negedge clk);
    n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL single_pulse got %0b want 0", send_val); end
  endtask

  task automatic test_backpressure();
    send_rdy = 1'b0;
    for (int i = 0; i < 2 * NS; i++) begin
      @(negedge clk);
      n_cmp++; if (recv_rdy !== 1'b1) begin n_err++; $display("FAIL bp_fill_rdy s%0d got %0b want 1", i, recv_rdy); end
      recv_msg = 32'(101 + i); recv_val = 1'b1;
    end
    @(negedge clk);
    recv_msg = 32'd117;
    n_cmp++; if (recv_rdy !== 1'b0) begin n_err++; $display("FAIL bp_both_full_rdy got %0b want 0", recv_rdy); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (recv_rdy !== 1'b0) begin n_err++; $display("FAIL bp_hold_rdy c%0d got %0b want 0", c, recv_rdy); end
      n_cmp++; if (send_val !== 1'b1) begin n_err++; $display("FAIL bp_hold_val c%0d got %0b want 1", c, send_val); end
      n_cmp++; if (send_msg[0] !== 32'd101) begin n_err++; $display("FAIL bp_hold_msg c%0d got %0d want 101", c, send_msg[0]); end
    end
    for (int k = 0; k < NS; k++) begin
      n_cmp++; if (send_msg[k] !== 32'(101 + k)) begin n_err++; $display("FAIL bp_frameA[%0d] got %0d want %0d", k, send_msg[k], 101 + k); end
    end
    send_rdy = 1'b1;
    n_cmp++; if (recv_rdy !== 1'b0) begin n_err++; $display("FAIL bp_no_comb_rdy got %0b want 0", recv_rdy); end
    @(negedge clk);
    n_cmp++; if (send_val !== 1'b1) begin n_err++; $display("FAIL bp_frameB_val got %0b want 1", send_val); end
    n_cmp++; if (recv_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_rerise got %0b want 1", recv_rdy); end
    for (int k = 0; k < NS; k++) begin
      n_cmp++; if (send_msg[k] !== 32'(109 + k)) begin n_err++; $display("FAIL bp_frameB[%0d] got %0d want %0d", k, send_msg[k], 109 + k); end
    end
    for (int i = 1; i < NS; i++) begin
      @(negedge clk);
      n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL bp_tail_val s%0d got %0b want 0", i, send_val); end
      recv_msg = 32'(117 + i);
    end
    @(negedge clk);
    recv_val = 1'b0;
    n_cmp++; if (send_val !== 1'b1) begin n_err++; $display("FAIL bp_frameC_val got %0b want 1", send_val); end
    for (int k = 0; k < NS; k++) begin
      n_cmp++; if (send_msg[k] !== 32'(117 + k)) begin n_err++; $display("FAIL bp_frameC[%0d] got %0d want %0d", k, send_msg[k], 117 + k); end
    end
    @(negedge clk);
    n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL bp_drained got %0b want 0", send_val); end
  endtask

  task automatic test_back_to_back();
    int frames;
    frames = 0;
    send_rdy = 1'b1;
    for (int i = 0; i < 8 * NS + 4; i++) begin
      @(negedge clk);
      if (send_val === 1'b1) begin
        for (int k = 0; k < NS; k++) begin
          n_cmp++;
          if (send_msg[k] !== 32'(200 + NS * frames + k)) begin
            n_err++; $display("FAIL stream_f%0d[%0d] got %0d want %0d", frames, k, send_msg[k], 200 + NS * frames + k);
          end
        end
        frames++;
      end
      if (i < 8 * NS) begin
        n_cmp++; if (recv_rdy !== 1'b1) begin n_err++; $display("FAIL stream_rdy s%0d got %0b want 1", i, recv_rdy); end
        recv_msg = 32'(200 + i); recv_val = 1'b1;
      end else begin
        recv_val = 1'b0;
      end
    end
    n_cmp++; if (frames !== 8) begin n_err++; $display("FAIL stream_frames got %0d want 8", frames); end
  endtask

  task automatic test_coincident();
    send_rdy = 1'b0;
    for (int i = 0; i < 2 * NS - 1; i++) begin
      @(negedge clk);
      recv_msg = (i < NS) ? 32'(300 + i) : 32'(310 + i - NS); recv_val = 1'b1;
    end
    @(negedge clk);
    n_cmp++; if (send_val !== 1'b1) begin n_err++; $display("FAIL coin_A_val got %0b want 1", send_val); end
    n_cmp++; if (send_msg[7] !== 32'd307) begin n_err++; $display("FAIL coin_A_last got %0d want 307", send_msg[7]); end
    n_cmp++; if (recv_rdy !== 1'b1) begin n_err++; $display("FAIL coin_pre_rdy got %0b want 1", recv_rdy); end
    recv_msg = 32'd317; send_rdy = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    n_cmp++; if (send_val !== 1'b1) begin n_err++; $display("FAIL coin_B_val got %0b want 1", send_val); end
    n_cmp++; if (recv_rdy !== 1'b1) begin n_err++; $display("FAIL coin_rdy got %0b want 1", recv_rdy); end
    for (int k = 0; k < NS; k++) begin
      n_cmp++; if (send_msg[k] !== 32'(310 + k)) begin n_err++; $display("FAIL coin_B[%0d] got %0d want %0d", k, send_msg[k], 310 + k); end
    end
    @(negedge clk);
    n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL coin_empty got %0b want 0", send_val); end
  endtask

  task automatic test_reset_mid_frame();
    send_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      recv_msg = 32'(400 + i); recv_val = 1'b1;
    end
    @(negedge clk);
    recv_val = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (recv_rdy !== 1'b0) begin n_err++; $display("FAIL mid_reset_rdy got %0b want 0", recv_rdy); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL mid_no_val got %0b want 0", send_val); end
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      n_cmp++; if (send_val !== 1'b0) begin n_err++; $display("FAIL mid_early_val s%0d got %0b want 0", i, send_val); end
      recv_msg = 32'(500 + i); recv_val = 1'b1;
    end
    @(negedge clk);
    recv_val = 1'b0;
    n_cmp++; if (send_val !== 1'b1) begin n_err++; $display("FAIL mid_val got %0b want 1", send_val); end
    for (int k = 0; k < NS; k++) begin
      n_cmp++; if (send_msg[k] !== 32'(500 + k)) begin n_err++; $display("FAIL mid_frame[%0d] got %0d want %0d", k, send_msg[k], 500 + k); end
    end
    @(negedge clk);
  endtask

  initial begin
    sample_t init_s;
    init_s = '0;
    n_cmp = 0; n_err = 0;
    recv_msg = init_s; recv_val = 1'b0; send_rdy = 1'b0; reset = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_coincident();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
